// File: rtl/la_pkg.sv
// Shared encodings for the logic-analyser capture path: FSM states, one-hot sample
// modes and trigger polarity codes.
package la_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRETRIG = 3'd1,
      ST_ARMED   = 3'd2,
      ST_POST    = 3'd3,
      ST_DONE    = 3'd4
   } la_state_t;

   localparam logic [2:0] MODE1 = 3'b001;
   localparam logic [2:0] MODE2 = 3'b010;
   localparam logic [2:0] MODE3 = 3'b100;

   localparam logic POS_TRI = 1'b1;
   localparam logic NEG_TRI = 1'b0;

endpackage

// File: rtl/la_rate_div.sv
// Sample-rate divider: one-hot mode -> divisor, single-cycle tick at the end of
// each period; restarts whenever the mode changes.
module la_rate_div
   import la_pkg::*;
#(
   parameter int DIV_M1 = 1,
   parameter int DIV_M2 = 25,
   parameter int DIV_M3 = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] sampling_mode,
   output logic       tick,
   output logic       mode_valid,
   output logic       mode_chg
);

   localparam int DMAX  = (DIV_M1 > DIV_M2) ? ((DIV_M1 > DIV_M3) ? DIV_M1 : DIV_M3)
                                            : ((DIV_M2 > DIV_M3) ? DIV_M2 : DIV_M3);
   localparam int CNT_W = (DMAX > 1) ? $clog2(DMAX) : 1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last;
   logic [2:0]       mode_q;

   always_comb begin
      last       = '0;
      mode_valid = 1'b1;
      case (sampling_mode)
         MODE1:   last = CNT_W'(DIV_M1 - 1);
         MODE2:   last = CNT_W'(DIV_M2 - 1);
         MODE3:   last = CNT_W'(DIV_M3 - 1);
         default: mode_valid = 1'b0;
      endcase
   end

   assign mode_chg = (sampling_mode != mode_q);
   assign tick     = mode_valid && !mode_chg && (cnt == last);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         mode_q <= '0;
      end else begin
         mode_q <= sampling_mode;
         if (!mode_valid || mode_chg || cnt == last) cnt <= '0;
         else                                       cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture sequencer: synchronises probes/trigger, detects the trigger edge and
// fills the circular sample RAM around it, reporting where readout starts.
module la_capture_ctrl
   import la_pkg::*;
#(
   parameter int DEPTH    = 512,
   parameter int PRE_TRIG = 64,
   parameter int DIV_M1   = 1,
   parameter int DIV_M2   = 25,
   parameter int DIV_M3   = 250,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        signal,
   input  logic              trigger,
   input  logic              tri_mode,
   input  logic [2:0]        sampling_mode,
   input  logic              sampling_clr_n,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [3:0]        wr_data,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [ADDR_W-1:0] start_addr,
   output logic              busy,
   output logic              done
);

   localparam int                POST_N    = DEPTH - PRE_TRIG;
   localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRE_TRIG);
   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
   localparam logic [ADDR_W:0]   POST_LAST = (ADDR_W+1)'(POST_N - 1);

   la_state_t         state, state_nxt;
   logic [3:0]        sig_s1, sig_s2;
   logic              trg_s1, trg_s2, trg_prev;
   logic              tick, mode_valid, mode_chg;
   logic [ADDR_W-1:0] ptr, pre_cnt;
   logic [ADDR_W:0]   post_cnt;
   logic              edge_lat, edge_now;
   logic              do_wr, restart, clear, trig_hit, edge_set;

   la_rate_div #(.DIV_M1(DIV_M1), .DIV_M2(DIV_M2), .DIV_M3(DIV_M3)) u_div (
      .clk           (clk),
      .rst           (rst),
      .sampling_mode (sampling_mode),
      .tick          (tick),
      .mode_valid    (mode_valid),
      .mode_chg      (mode_chg)
   );

   // Edge is taken purely from the trigger history, so flipping tri_mode alone is silent.
   assign edge_now = tri_mode ? (trg_s2 & ~trg_prev) : (~trg_s2 & trg_prev);
   assign busy     = (state == ST_PRETRIG) || (state == ST_ARMED) || (state == ST_POST);
   assign done     = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_s1 <= '0; sig_s2 <= '0;
         trg_s1 <= 1'b0; trg_s2 <= 1'b0; trg_prev <= 1'b0;
         state  <= ST_IDLE;
      end else begin
         sig_s1 <= signal;  sig_s2 <= sig_s1;
         trg_s1 <= trigger; trg_s2 <= trg_s1; trg_prev <= trg_s2;
         state  <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      do_wr     = 1'b0;
      restart   = 1'b0;
      clear     = 1'b0;
      trig_hit  = 1'b0;
      edge_set  = 1'b0;
      if (!sampling_clr_n) begin
         state_nxt = ST_IDLE;
         clear     = 1'b1;
      end else if (!mode_valid) begin
         state_nxt = ST_IDLE;
      end else if (mode_chg && busy) begin
         state_nxt = ST_PRETRIG;
         restart   = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt = ST_PRETRIG;
               restart   = 1'b1;
            end
            ST_PRETRIG: if (tick) begin
               do_wr = 1'b1;
               if (pre_cnt == PRE_LAST) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
               if (tick) begin
                  do_wr = 1'b1;
                  if (edge_lat || edge_now) begin
                     trig_hit  = 1'b1;
                     state_nxt = (POST_N == 1) ? ST_DONE : ST_POST;
                  end
               end else if (edge_now) begin
                  edge_set = 1'b1;
               end
            end
            ST_POST: if (tick) begin
               do_wr = 1'b1;
               if (post_cnt == POST_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: ;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         trig_addr  <= '0;
         start_addr <= '0;
         ptr        <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         edge_lat   <= 1'b0;
      end else begin
         wr_en <= do_wr;
         if (clear) begin
            ptr        <= '0;
            edge_lat   <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
         end
         if (restart) begin
            ptr      <= '0;
            pre_cnt  <= '0;
            edge_lat <= 1'b0;
         end
         if (do_wr) begin
            wr_addr <= ptr;
            wr_data <= sig_s2;
            ptr     <= ptr + 1'b1;
            if (state == ST_PRETRIG) pre_cnt  <= pre_cnt + 1'b1;
            if (state == ST_POST)    post_cnt <= post_cnt + 1'b1;
         end
         if (edge_set) edge_lat <= 1'b1;
         if (trig_hit) begin
            trig_addr  <= ptr;
            start_addr <= ptr - PRE_A;
            post_cnt   <= (ADDR_W+1)'(1);
            edge_lat   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl: trigger placement, wrap, clear and mode restart.
module tb_la_capture_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] signal;
   logic       trigger, tri_mode, sampling_clr_n;
   logic [2:0] sampling_mode;
   logic       wr_en, busy, done;
   logic [8:0] wr_addr, trig_addr, start_addr;
   logic [3:0] wr_data;

   int n_chk = 0, n_err = 0;
   int cyc = 0, wr_cnt = 0, c0, n0;
   logic [8:0] last_addr = '0;
   logic [3:0] last_data = '0;
   logic       wrap_seen = 1'b0;

   la_capture_ctrl dut (
      .clk(clk), .rst(rst), .signal(signal), .trigger(trigger), .tri_mode(tri_mode),
      .sampling_mode(sampling_mode), .sampling_clr_n(sampling_clr_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .trig_addr(trig_addr),
      .start_addr(start_addr), .busy(busy), .done(done)
   );

   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
      cyc++;
      if (wr_en) begin
         if (wr_cnt > 0 && last_addr == 9'd511 && wr_addr == 9'd0) wrap_seen = 1'b1;
         last_addr = wr_addr;
         last_data = wr_data;
         wr_cnt++;
      end
   endtask

   task automatic wait_cnt(input string tag, input int k, input int limit);
      int t = 0;
      while (wr_cnt < k && t < limit) begin step(); t++; end
      if (wr_cnt < k) chk(tag, wr_cnt, k);
   endtask

   task automatic wait_done(input string tag, input int limit);
      int t = 0;
      while (!done && t < limit) begin step(); t++; end
      if (!done) chk(tag, done, 1);
   endtask

   task automatic start_cap(input logic [2:0] mode, input logic tm);
      sampling_clr_n = 1'b0;
      trigger        = 1'b0;
      repeat (3) step();
      sampling_mode = mode;
      tri_mode      = tm;
      step();
      sampling_clr_n = 1'b1;
      wr_cnt    = 0;
      wrap_seen = 1'b0;
   endtask

   initial begin
      rst = 1'b1; signal = 4'h5; trigger = 1'b0; tri_mode = 1'b1;
      sampling_mode = 3'b001; sampling_clr_n = 1'b0;
      repeat (4) step();
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_trig", trig_addr, 0);
      chk("rst_start", start_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;

      // 1: MODE1 rising trigger landing on write 100
      start_cap(3'b001, 1'b1);
      wait_cnt("t1_w6", 6, 50);
      signal = 4'hA;
      wait_cnt("t1_w8", 8, 50);
      chk("t1_lat_old", last_data, 4'h5);
      wait_cnt("t1_w9", 9, 50);
      chk("t1_lat_new", last_data, 4'hA);
      wait_cnt("t1_w10", 10, 50);
      c0 = cyc;
      wait_cnt("t1_w20", 20, 50);
      chk("t1_gap", cyc - c0, 10);
      wait_cnt("t1_w98", 98, 200);
      trigger = 1'b1;
      wait_done("t1_done", 2000);
      chk("t1_trig", trig_addr, 100);
      chk("t1_start", start_addr, 36);
      chk("t1_nwr", wr_cnt, 548);
      chk("t1_last", last_addr, 35);
      n0 = wr_cnt;
      repeat (20) step();
      chk("t1_frozen", wr_cnt, n0);
      chk("t1_hold", done, 1);

      // 2: MODE2 falling trigger, rising edge must be ignored
      start_cap(3'b010, 1'b0);
      wait_cnt("t2_w10", 10, 2000);
      c0 = cyc;
      wait_cnt("t2_w11", 11, 100);
      chk("t2_gap", cyc - c0, 25);
      wait_cnt("t2_w66", 66, 3000);
      trigger = 1'b1;
      wait_cnt("t2_w70", 70, 300);
      chk("t2_rise_ign", trig_addr, 0);
      chk("t2_busy", busy, 1);
      trigger = 1'b0;
      wait_cnt("t2_w200", 200, 5000);
      c0 = cyc;
      wait_cnt("t2_w201", 201, 100);
      chk("t2_gap_post", cyc - c0, 25);
      wait_done("t2_done", 20000);
      chk("t2_trig", trig_addr, 70);
      chk("t2_start", start_addr, 6);

      // 3: edge during pre-trigger ignored, later edge triggers
      start_cap(3'b001, 1'b1);
      wait_cnt("t3_w28", 28, 100);
      trigger = 1'b1;
      wait_cnt("t3_w41", 41, 100);
      trigger = 1'b0;
      wait_cnt("t3_w78", 78, 100);
      trigger = 1'b1;
      wait_done("t3_done", 2000);
      chk("t3_trig", trig_addr, 80);
      chk("t3_start", start_addr, 16);

      // 4: trigger on write 600, pointer wraps
      start_cap(3'b001, 1'b1);
      wait_cnt("t4_w598", 598, 1000);
      trigger = 1'b1;
      wait_done("t4_done", 2000);
      chk("t4_wrap", wrap_seen, 1);
      chk("t4_trig", trig_addr, 88);
      chk("t4_start", start_addr, 24);

      // 5: clear mid-POST, then restart from address 0
      start_cap(3'b001, 1'b1);
      wait_cnt("t5_w98", 98, 200);
      trigger = 1'b1;
      wait_cnt("t5_w150", 150, 200);
      chk("t5_busy_pre", busy, 1);
      sampling_clr_n = 1'b0;
      step();
      chk("t5_wr_en", wr_en, 0);
      chk("t5_done", done, 0);
      chk("t5_busy", busy, 0);
      chk("t5_trig_clr", trig_addr, 0);
      repeat (2) step();
      sampling_clr_n = 1'b1;
      wr_cnt = 0;
      wait_cnt("t5_first", 1, 20);
      chk("t5_addr0", last_addr, 0);
      chk("t5_busy_re", busy, 1);

      // 6: mode change mid-ARMED restarts at MODE3 rate; invalid mode idles
      start_cap(3'b001, 1'b1);
      wait_cnt("t6_w71", 71, 200);
      sampling_mode = 3'b100;
      c0 = cyc;
      wr_cnt = 0;
      wait_cnt("t6_first", 1, 400);
      chk("t6_addr0", last_addr, 0);
      chk("t6_lat", cyc - c0, 251);
      c0 = cyc;
      wait_cnt("t6_second", 2, 400);
      chk("t6_addr1", last_addr, 1);
      chk("t6_gap", cyc - c0, 250);
      sampling_mode = 3'b011;
      n0 = wr_cnt;
      repeat (300) step();
      chk("t6_nowr", wr_cnt, n0);
      chk("t6_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
